// File: rtl/vdc_xferq.sv
`default_nettype none
// ============================================================================
// Module   : vdc_xferq
// Desc     : Queued CPU-to-VRAM transfer engine (READ/WRITE/FILL/COPY) on a
//            request/grant slot port. Option macro: VDC_XFER_DESCEND_EN.
// Revision : 1.0
// ============================================================================
module vdc_xferq #(
  parameter int ADDR_WIDTH  = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter int WC_WIDE     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_stb,
  input  logic                  rd_stb,
  input  logic [5:0]            regA,
  input  logic [7:0]            db_in,
  input  logic                  reg_copy,
  input  logic                  reg_desc,
  output logic [15:0]           reg_ua,
  output logic [15:0]           reg_ba,
  output logic [15:0]           reg_wc,
  output logic [7:0]            reg_da,
  output logic                  busy,
  output logic                  full,
  output logic                  ovf,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wd,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [7:0]            mem_rd
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int EW = 17;
  localparam logic [PW:0] c_ptr_one = {{PW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_FILL    = 3'd3,
    S_COPY_RD = 3'd4,
    S_COPY_WR = 3'd5
  } state_t;

  state_t          state_q;
  logic [EW-1:0]   q_mem [QUEUE_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic [15:0]     ua_q, ba_q, wc_q, cnt_q;
  logic [7:0]      da_q, wch_q, wda_q, cda_q;
  logic            desc_q, rwait_q, ovf_q;
  logic            mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]      mem_wd_q;

  logic w_empty, w_full, w_wr_hit, w_push, w_pop, w_accept, w_drop;
  logic [EW-1:0] w_entry, w_head;
  logic          h_rd, h_copy, h_desc;
  logic [5:0]    h_reg;
  logic [7:0]    h_data;
  logic [15:0]   w_step, w_ua_step, w_ba_step, w_ua_pop, w_cnt_dec, w_cnt_load;
  logic          w_cnt_last;
  logic          w_unused;

  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign w_wr_hit = wr_stb && ((regA == 6'd18) || (regA == 6'd19) ||
                    (regA == 6'd29) || (regA == 6'd30) || (regA == 6'd31) ||
                    (regA == 6'd32) || (regA == 6'd33));
  assign w_push   = w_wr_hit || (rd_stb && !wr_stb);
  assign w_pop    = (state_q == S_IDLE) && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is kept.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = (w_push && !w_accept) || (wr_stb && rd_stb);
  assign w_entry  = {!wr_stb, regA, db_in, reg_copy, reg_desc};

  assign w_head = q_mem[rd_ptr_q[PW-1:0]];
  assign h_rd   = w_head[16];
  assign h_reg  = w_head[15:10];
  assign h_data = w_head[9:2];
  assign h_copy = w_head[1];
  assign h_desc = w_head[0];

  assign w_step     = desc_q ? 16'hFFFF : 16'h0001;
  assign w_ua_step  = ua_q + w_step;
  assign w_ba_step  = ba_q + w_step;
  assign w_cnt_last = (cnt_q == 16'd1);
  // Count 0 wraps to the top of its range, giving 256 or 65536 elements.
  assign w_cnt_dec  = (WC_WIDE != 0) ? (cnt_q - 16'd1) : {8'h00, cnt_q[7:0] - 8'd1};
  assign w_cnt_load = {((WC_WIDE != 0) ? wch_q : 8'h00), h_data};

  always_comb begin
    w_ua_pop = ua_q;
    if (h_rd)                w_ua_pop = ua_q + 16'd1;
    else if (h_reg == 6'd18) w_ua_pop = {h_data, ua_q[7:0]};
    else if (h_reg == 6'd19) w_ua_pop = {ua_q[15:8], h_data};
  end

  always_ff @(posedge clk) begin
    if (w_accept) q_mem[wr_ptr_q[PW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ua_q       <= '0;
      ba_q       <= '0;
      wc_q       <= '0;
      cnt_q      <= '0;
      da_q       <= '0;
      wch_q      <= '0;
      wda_q      <= '0;
      cda_q      <= '0;
      desc_q     <= 1'b0;
      rwait_q    <= 1'b0;
      ovf_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '1;
      mem_wd_q   <= '0;
    end else begin
      if (w_accept) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (w_pop)    rd_ptr_q <= rd_ptr_q + c_ptr_one;
      if (w_drop)   ovf_q    <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            if (h_rd || (h_reg == 6'd18) || (h_reg == 6'd19)) begin
              ua_q       <= w_ua_pop;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= w_ua_pop[ADDR_WIDTH-1:0];
              state_q    <= S_READ;
            end else if (h_reg == 6'd31) begin
              wda_q      <= h_data;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= ua_q[ADDR_WIDTH-1:0];
              mem_wd_q   <= h_data;
              state_q    <= S_WRITE;
            end else if (h_reg == 6'd29) begin
              if (WC_WIDE != 0) wch_q <= h_data;
            end else if (h_reg == 6'd32) begin
              ba_q[15:8] <= h_data;
            end else if (h_reg == 6'd33) begin
              ba_q[7:0]  <= h_data;
            end else if (h_reg == 6'd30) begin
              wc_q      <= w_cnt_load;
              cnt_q     <= w_cnt_load;
`ifdef VDC_XFER_DESCEND_EN
              desc_q    <= h_desc;
`else
              desc_q    <= 1'b0;
`endif
              mem_req_q <= 1'b1;
              if (h_copy) begin
                mem_we_q   <= 1'b0;
                mem_addr_q <= ba_q[ADDR_WIDTH-1:0];
                state_q    <= S_COPY_RD;
              end else begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= ua_q[ADDR_WIDTH-1:0];
                mem_wd_q   <= wda_q;
                state_q    <= S_FILL;
              end
            end
          end
        end

        S_READ, S_COPY_RD: begin
          if (rwait_q) begin
            if (mem_rvalid) begin
              rwait_q <= 1'b0;
              if (state_q == S_READ) begin
                da_q    <= mem_rd;
                state_q <= S_IDLE;
              end else begin
                cda_q   <= mem_rd;
                ba_q    <= w_ba_step;
                state_q <= S_COPY_WR;
              end
            end
          end else if (mem_req_q) begin
            if (mem_gnt) begin
              mem_req_q <= 1'b0;
              rwait_q   <= 1'b1;
            end
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= (state_q == S_READ) ? ua_q[ADDR_WIDTH-1:0] : ba_q[ADDR_WIDTH-1:0];
          end
        end

        S_WRITE: begin
          if (mem_req_q && mem_gnt) begin
            mem_req_q <= 1'b0;
            ua_q      <= ua_q + 16'd1;
            state_q   <= S_READ;
          end
        end

        S_FILL, S_COPY_WR: begin
          if (mem_req_q) begin
            if (mem_gnt) begin
              mem_req_q <= 1'b0;
              ua_q      <= w_ua_step;
              cnt_q     <= w_cnt_dec;
              if (w_cnt_last)              state_q <= S_IDLE;
              else if (state_q == S_COPY_WR) state_q <= S_COPY_RD;
            end
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= ua_q[ADDR_WIDTH-1:0];
            mem_wd_q   <= (state_q == S_FILL) ? wda_q : cda_q;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_unused = h_desc;

  assign reg_ua   = ua_q;
  assign reg_ba   = ba_q;
  assign reg_wc   = wc_q;
  assign reg_da   = da_q;
  assign busy     = !w_empty || (state_q != S_IDLE);
  assign full     = w_full;
  assign ovf      = ovf_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;

endmodule
`default_nettype wire
